// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared definitions for the cpu_seq instruction sequencer.
//   - sequencer state encoding
//   - opcode constants (MOV, BR, CMP, HALT)
//   - instruction field positions
//   - decoded-instruction struct produced by cpu_seq_decode
//
// Instruction layout (32 bits):
//   [31:27] opcode        [26] predicated-branch enable   [25:23] predicate select
//   [22]    predicate inv [20:16] destination register
//   [15:0]  immediate (MOV, BR); for register ops [12:10] cc, [9:5] src a, [4:0] src b
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_HALTED     = 3'd4
  } state_t;

  localparam logic [4:0] OP_MOV  = 5'h01;
  localparam logic [4:0] OP_BR   = 5'h02;
  localparam logic [4:0] OP_CMP  = 5'h03;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int PCOND_B  = 26;
  localparam int PSEL_HI  = 25;
  localparam int PSEL_LO  = 23;
  localparam int PINV_B   = 22;
  localparam int RZ_HI    = 20;
  localparam int RZ_LO    = 16;
  localparam int IMM_HI   = 15;
  localparam int CC_HI    = 12;
  localparam int CC_LO    = 10;
  localparam int RA_HI    = 9;
  localparam int RA_LO    = 5;
  localparam int RB_HI    = 4;

  typedef struct packed {
    logic [4:0]  op;
    logic        is_mov;
    logic        is_branch;
    logic        is_cmp;
    logic        is_halt;
    logic        has_imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rz;
    logic [2:0]  cc;
    logic [15:0] imm;
    logic [2:0]  pred_sel;
    logic        pred_cond;
    logic        pred_inv;
  } dec_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// cpu_seq_decode: purely combinational decode of the latched instruction word.
// Ports:
//   inst  in   latched 32-bit instruction
//   dec   out  opcode class flags, immediate flag, register/predicate selects,
//              compare condition (zero for non-CMP), raw 16-bit immediate
module cpu_seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  // bit 21 is reserved in every format
  logic unused_rsvd;
  assign unused_rsvd = inst[21];

  always_comb begin
    dec           = '0;
    dec.op        = inst[OPC_HI:OPC_LO];
    dec.is_mov    = (dec.op == OP_MOV);
    dec.is_branch = (dec.op == OP_BR);
    dec.is_cmp    = (dec.op == OP_CMP);
    dec.is_halt   = (dec.op == OP_HALT);
    dec.has_imm   = dec.is_mov | dec.is_branch;
    dec.ra        = inst[RA_HI:RA_LO];
    dec.rb        = inst[RB_HI:0];
    dec.rz        = inst[RZ_HI:RZ_LO];
    dec.cc        = dec.is_cmp ? inst[CC_HI:CC_LO] : 3'd0;
    dec.imm       = inst[IMM_HI:0];
    dec.pred_sel  = inst[PSEL_HI:PSEL_LO];
    dec.pred_cond = inst[PCOND_B];
    dec.pred_inv  = inst[PINV_B];
  end

endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multicycle FETCH/DECODE/EXECUTE/WRITE_BACK sequencer with HALT.
// Drives an external ALU and register bank; instruction fetch uses a req/ack
// handshake so memory may insert wait states.
// Ports:
//   clk, reset                      clock, async active-high reset
//   imem_req/addr/ack/data          instruction fetch handshake
//   rf_addr_a/b, rf_data_a/b        register source selects and read data
//   rf_we, rf_addr_z, rf_z_sel,
//   rf_data_z                       register / predicate write port
//   pred_addr, pred_val             predicate read for conditional branches
//   alu_opcode, alu_cc, alu_a/b,
//   alu_z                           external ALU
//   pc, halted                      status
// Build option: CPU_SEQ_PRED_BRANCH_EN enables predicated branches; without it
// every BR is taken and the predicate port is idle.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               REG_SEL  = 5,
  parameter int               PRED_SEL = 3,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [WIDTH-1:0]    imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [REG_SEL-1:0]  rf_addr_a,
  output logic [REG_SEL-1:0]  rf_addr_b,
  input  logic [WIDTH-1:0]    rf_data_a,
  input  logic [WIDTH-1:0]    rf_data_b,
  output logic                rf_we,
  output logic [REG_SEL-1:0]  rf_addr_z,
  output logic                rf_z_sel,
  output logic [WIDTH-1:0]    rf_data_z,
  output logic [PRED_SEL-1:0] pred_addr,
  input  logic                pred_val,
  output logic [4:0]          alu_opcode,
  output logic [2:0]          alu_cc,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_z,
  output logic [WIDTH-1:0]    pc,
  output logic                halted
);

  state_t           state, state_nx;
  logic [31:0]      inst;
  logic [WIDTH-1:0] pc_q, opa, opb, result, imm_ext, opnd_a, opnd_b;
  logic             taken, br_taken;
  dec_t             dec;

  cpu_seq_decode u_decode (.inst(inst), .dec(dec));

  assign imm_ext = WIDTH'($signed(dec.imm));
  assign opnd_a  = dec.has_imm ? imm_ext : rf_data_a;
  assign opnd_b  = dec.has_imm ? '0      : rf_data_b;

`ifdef CPU_SEQ_PRED_BRANCH_EN
  assign br_taken  = !dec.pred_cond || (pred_val ^ dec.pred_inv);
  assign pred_addr = PRED_SEL'(dec.pred_sel);
  logic unused_dec;
  assign unused_dec = dec.is_mov;
`else
  assign br_taken  = 1'b1;
  assign pred_addr = '0;
  logic unused_dec;
  assign unused_dec = ^{dec.is_mov, dec.pred_sel, dec.pred_cond, dec.pred_inv, pred_val};
`endif

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign rf_addr_a  = REG_SEL'(dec.ra);
  assign rf_addr_b  = REG_SEL'(dec.rb);
  assign rf_addr_z  = REG_SEL'(dec.rz);
  assign rf_z_sel   = dec.is_cmp;
  assign rf_data_z  = result;
  assign alu_opcode = dec.op;
  assign alu_cc     = dec.cc;
  // operands are visible while being selected in DECODE, then held from the latch
  assign alu_a      = (state == S_DECODE) ? opnd_a : opa;
  assign alu_b      = (state == S_DECODE) ? opnd_b : opb;

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        // state already sits in FETCH during reset; keep the request quiet
        imem_req = !reset;
        if (imem_ack) state_nx = S_DECODE;
      end
      S_DECODE:     state_nx = dec.is_halt ? S_HALTED : S_EXECUTE;
      S_EXECUTE:    state_nx = S_WRITE_BACK;
      S_WRITE_BACK: begin
        rf_we    = !dec.is_branch;
        state_nx = S_FETCH;
      end
      S_HALTED:     halted = 1'b1;
      default:      state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      inst   <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      taken  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:   if (imem_ack) inst <= imem_data;
        S_DECODE: begin
          opa <= opnd_a;
          opb <= opnd_b;
        end
        S_EXECUTE: begin
          result <= alu_z;
          taken  <= dec.is_branch && br_taken;
        end
        S_WRITE_BACK: pc_q <= taken ? pc_q + imm_ext : pc_q + WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: self-checking bench for cpu_seq. The bench plays instruction
// memory (random wait states, stray acks), register/predicate banks and ALU,
// and predicts every write and next fetch address with an instruction-level
// model.
module tb_cpu_seq;
  import cpu_seq_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] RPC = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_ack, rf_we, rf_z_sel, pred_val, halted;
  logic [W-1:0]  imem_addr, rf_data_a, rf_data_b, rf_data_z, alu_a, alu_b, alu_z, pc;
  logic [31:0]   imem_data;
  logic [4:0]    rf_addr_a, rf_addr_b, rf_addr_z, alu_opcode;
  logic [2:0]    pred_addr, alu_cc;

  int checks = 0;
  int failures = 0;

  logic [31:0] regs  [32] = '{default: '0};
  logic        preds [8]  = '{default: 1'b0};
  logic [31:0] mregs [32];
  logic        mpreds [8];
  logic [31:0] mpc;

  typedef struct {
    int          cycles;
    int          we_cnt;
    logic [31:0] fetch_addr, next_addr, pc0, z_data;
    logic [4:0]  z_addr;
    logic        zsel;
    bit          req_ok, addr_stable, pc_stable, halted_seen;
  } obs_t;

  typedef struct {
    bit          we, halt;
    logic [4:0]  addr;
    logic        zsel;
    logic [31:0] data, next;
  } exp_t;

  cpu_seq #(.WIDTH(W), .REG_SEL(5), .PRED_SEL(3), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rf_we(rf_we), .rf_addr_z(rf_addr_z), .rf_z_sel(rf_z_sel), .rf_data_z(rf_data_z),
    .pred_addr(pred_addr), .pred_val(pred_val),
    .alu_opcode(alu_opcode), .alu_cc(alu_cc), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // environment ALU: MOV/BR pass operand a, CMP yields a 0/1 flag, others add
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [2:0] cc);
    logic r;
    if (op == OP_CMP) begin
      case (cc)
        3'd0:    r = (a == b);
        3'd1:    r = (a < b);
        3'd2:    r = ($signed(a) < $signed(b));
        default: r = (a != b);
      endcase
      return {31'b0, r};
    end
    if (op == OP_MOV || op == OP_BR) return a;
    return a + b + {27'b0, op};
  endfunction

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];
  assign pred_val  = preds[pred_addr];
  assign alu_z     = alu_fn(alu_opcode, alu_a, alu_b, alu_cc);

  always @(posedge clk)
    if (rf_we) begin
      if (rf_z_sel) preds[rf_addr_z[2:0]] <= rf_data_z[0];
      else          regs[rf_addr_z]       <= rf_data_z;
    end

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic cond, input logic [2:0] ps,
                                       input logic inv, input logic [4:0] rz, input logic [15:0] imm);
    return {op, cond, ps, inv, 1'b0, rz, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [4:0] rz, input logic [2:0] cc,
                                       input logic [4:0] ra, input logic [4:0] rb);
    return {op, 6'b0, rz, 3'b0, cc, ra, rb};
  endfunction

  // Instruction-level reference: effect of one instruction on the architectural state
  task automatic model_step(input logic [31:0] ins, output exp_t e);
    logic [4:0]  op;
    logic [31:0] imm, a, b, z;
    logic        tk;
    op = ins[31:27];
    imm = {{16{ins[15]}}, ins[15:0]};
    e.we = 0; e.halt = 0; e.addr = '0; e.zsel = 0; e.data = '0; e.next = mpc;
    if (op == OP_HALT) begin
      e.halt = 1;
    end else begin
      a = (op == OP_MOV || op == OP_BR) ? imm : mregs[ins[9:5]];
      b = (op == OP_MOV || op == OP_BR) ? 32'd0 : mregs[ins[4:0]];
      z = alu_fn(op, a, b, (op == OP_CMP) ? ins[12:10] : 3'd0);
      if (op == OP_BR) begin
        tk = 1'b1;
`ifdef CPU_SEQ_PRED_BRANCH_EN
        if (ins[26]) tk = mpreds[ins[25:23]] ^ ins[22];
`endif
        e.next = tk ? mpc + imm : mpc + 1;
      end else begin
        e.we = 1; e.addr = ins[20:16]; e.zsel = (op == OP_CMP); e.data = z;
        if (e.zsel) mpreds[ins[18:16]] = z[0];
        else        mregs[ins[20:16]] = z;
        e.next = mpc + 1;
      end
    end
    mpc = e.next;
  endtask

  // Serve one fetch (after `waits` idle cycles) and watch the DUT until it
  // requests the next instruction or 20 cycles pass. Called at negedge+1 in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int waits, input bit noise, output obs_t o);
    o.cycles = -1; o.we_cnt = 0; o.next_addr = 'x; o.z_data = 'x; o.z_addr = 'x; o.zsel = 'x;
    o.fetch_addr = imem_addr; o.pc0 = pc;
    o.req_ok = 1; o.addr_stable = 1; o.pc_stable = 1; o.halted_seen = 0;
    for (int c = 1; c <= waits + 21; c++) begin
      if (c <= waits + 1) begin
        if (imem_req !== 1'b1) o.req_ok = 0;
        if (imem_addr !== o.fetch_addr) o.addr_stable = 0;
      end else if (imem_req === 1'b1) begin
        o.cycles = c - 1;
        o.next_addr = imem_addr;
        break;
      end
      if (pc !== o.pc0) o.pc_stable = 0;
      if (halted === 1'b1) o.halted_seen = 1;
      if (rf_we === 1'b1) begin
        o.we_cnt++; o.z_data = rf_data_z; o.z_addr = rf_addr_z; o.zsel = rf_z_sel;
      end
      if (c <= waits) begin
        imem_ack = 1'b0; imem_data = $urandom;
      end else if (c == waits + 1) begin
        imem_ack = 1'b1; imem_data = ins;
      end else begin
        imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0; imem_data = $urandom;
      end
      @(negedge clk); #1;
    end
    imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    mpc = RPC;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RPC); end
    imem_ack = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    mpc = RPC;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL release_addr got=%h exp=%h", imem_addr, RPC); end
    e.we = 0;
  endtask

  task automatic test_mov();
    obs_t o; exp_t e;
    model_step(mk_i(OP_MOV, 0, 0, 0, 5'd3, 16'h8001), e);
    run_instr(mk_i(OP_MOV, 0, 0, 0, 5'd3, 16'h8001), 0, 0, o);
    checks++; if (o.cycles !== 4) begin failures++; $display("FAIL mov_latency got=%0d exp=4", o.cycles); end
    checks++; if (o.we_cnt !== 1) begin failures++; $display("FAIL mov_we_cnt got=%0d exp=1", o.we_cnt); end
    checks++; if (o.z_data !== 32'hFFFF8001) begin failures++; $display("FAIL mov_data got=%h exp=ffff8001", o.z_data); end
    checks++; if (o.z_addr !== 5'd3 || o.zsel !== 1'b0) begin failures++; $display("FAIL mov_dest got=%0d/%b exp=3/0", o.z_addr, o.zsel); end
    checks++; if (o.next_addr !== 32'd1 || pc !== 32'd1) begin failures++; $display("FAIL mov_pc got=%h/%h exp=1", o.next_addr, pc); end
    checks++; if (!o.pc_stable) begin failures++; $display("FAIL mov_pc_stable got=0 exp=1"); end
    checks++; if (regs[3] !== 32'hFFFF8001) begin failures++; $display("FAIL mov_regfile got=%h exp=ffff8001", regs[3]); end
  endtask

  task automatic test_wait_states();
    obs_t o; exp_t e;
    model_step(mk_i(OP_MOV, 0, 0, 0, 5'd4, 16'h1234), e);
    run_instr(mk_i(OP_MOV, 0, 0, 0, 5'd4, 16'h1234), 3, 0, o);
    checks++; if (!o.req_ok || !o.addr_stable || o.fetch_addr !== 32'd1) begin
      failures++; $display("FAIL wait_req_hold got=req%0b stable%0b addr=%h exp=1/1/1", o.req_ok, o.addr_stable, o.fetch_addr); end
    checks++; if (o.cycles !== 7) begin failures++; $display("FAIL wait_latency got=%0d exp=7", o.cycles); end
    checks++; if (o.z_data !== 32'h1234 || o.z_addr !== 5'd4) begin failures++; $display("FAIL wait_data got=%h@%0d exp=1234@4", o.z_data, o.z_addr); end
  endtask

  task automatic test_branch();
    obs_t o; exp_t e;
    while (mpc != 32'd5) begin
      model_step(mk_i(OP_MOV, 0, 0, 0, 5'd9, 16'($urandom)), e);
      run_instr(mk_i(OP_MOV, 0, 0, 0, 5'd9, e.data[15:0]), 0, 1, o);
    end
    model_step(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'hFFFE), e);
    run_instr(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'hFFFE), 0, 1, o);
    checks++; if (o.fetch_addr !== 32'd5) begin failures++; $display("FAIL br_start_pc got=%h exp=5", o.fetch_addr); end
    checks++; if (o.we_cnt !== 0) begin failures++; $display("FAIL br_no_we got=%0d exp=0", o.we_cnt); end
    checks++; if (o.next_addr !== 32'd3) begin failures++; $display("FAIL br_back got=%h exp=3", o.next_addr); end
    do_reset();
    model_step(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'hFFFF), e);
    run_instr(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'hFFFF), 1, 0, o);
    checks++; if (o.next_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL br_wrap_down got=%h exp=ffffffff", o.next_addr); end
    model_step(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'h0001), e);
    run_instr(mk_i(OP_BR, 0, 0, 0, 5'd0, 16'h0001), 0, 0, o);
    checks++; if (o.next_addr !== 32'd0) begin failures++; $display("FAIL br_wrap_up got=%h exp=0", o.next_addr); end
  endtask

  task automatic test_pred_branch();
    obs_t o; exp_t e;
    logic [31:0] ins;
    logic [31:0] exp1, exp2;
    do_reset();
    ins = mk_i(OP_MOV, 0, 0, 0, 5'd1, 16'd7); model_step(ins, e); run_instr(ins, 0, 0, o);
    ins = mk_i(OP_MOV, 0, 0, 0, 5'd2, 16'd7); model_step(ins, e); run_instr(ins, 0, 0, o);
    ins = mk_r(OP_CMP, 5'd2, 3'd0, 5'd1, 5'd2); model_step(ins, e); run_instr(ins, 2, 1, o);
    checks++; if (o.zsel !== 1'b1 || o.z_data !== 32'd1 || o.z_addr !== 5'd2) begin
      failures++; $display("FAIL cmp_write got=sel%b data=%h addr=%0d exp=1/1/2", o.zsel, o.z_data, o.z_addr); end
    checks++; if (preds[2] !== 1'b1) begin failures++; $display("FAIL cmp_pred got=%b exp=1", preds[2]); end
    ins = mk_i(OP_BR, 1, 3'd2, 0, 5'd0, 16'd10); model_step(ins, e); run_instr(ins, 0, 1, o);
    checks++; if (o.next_addr !== 32'd13) begin failures++; $display("FAIL pbr_true got=%h exp=d", o.next_addr); end
    ins = mk_i(OP_MOV, 0, 0, 0, 5'd2, 16'd8); model_step(ins, e); run_instr(ins, 0, 0, o);
    ins = mk_r(OP_CMP, 5'd2, 3'd0, 5'd1, 5'd2); model_step(ins, e); run_instr(ins, 0, 0, o);
    checks++; if (preds[2] !== 1'b0) begin failures++; $display("FAIL cmp_pred_clr got=%b exp=0", preds[2]); end
`ifdef CPU_SEQ_PRED_BRANCH_EN
    exp1 = 32'd16; exp2 = 32'd26;
`else
    exp1 = 32'd25; exp2 = 32'd35;
`endif
    ins = mk_i(OP_BR, 1, 3'd2, 0, 5'd0, 16'd10); model_step(ins, e); run_instr(ins, 1, 1, o);
    checks++; if (o.next_addr !== exp1) begin failures++; $display("FAIL pbr_false got=%h exp=%h", o.next_addr, exp1); end
    ins = mk_i(OP_BR, 1, 3'd2, 1, 5'd0, 16'd10); model_step(ins, e); run_instr(ins, 0, 0, o);
    checks++; if (o.next_addr !== exp2) begin failures++; $display("FAIL pbr_inv got=%h exp=%h", o.next_addr, exp2); end
  endtask

  task automatic test_halt();
    obs_t o; exp_t e;
    logic [31:0] pc_before;
    pc_before = mpc;
    model_step({OP_HALT, 27'h0}, e);
    run_instr({OP_HALT, 27'h0}, 0, 1, o);
    checks++; if (!o.halted_seen || halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (o.cycles !== -1) begin failures++; $display("FAIL halt_no_fetch got=%0d exp=-1", o.cycles); end
    checks++; if (o.we_cnt !== 0 || !o.pc_stable || pc !== pc_before) begin
      failures++; $display("FAIL halt_frozen got=we%0d pc=%h exp=we0 pc=%h", o.we_cnt, pc, pc_before); end
    do_reset();
    checks++; if (pc !== RPC || imem_req !== 1'b1 || halted !== 1'b0) begin
      failures++; $display("FAIL halt_reset got=pc%h req%b halt%b exp=pc%h req1 halt0", pc, imem_req, halted, RPC); end
    model_step(mk_i(OP_MOV, 0, 0, 0, 5'd5, 16'h0042), e);
    run_instr(mk_i(OP_MOV, 0, 0, 0, 5'd5, 16'h0042), 0, 0, o);
    checks++; if (o.next_addr !== RPC + 1 || o.z_data !== 32'h42) begin failures++; $display("FAIL halt_resume got=%h/%h exp=%h/42", o.next_addr, o.z_data, RPC + 1); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [31:0] ins, pc_exp;
    int w, sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      ins = $urandom;
      if (sel < 2)       ins[31:27] = OP_MOV;
      else if (sel < 4)  ins[31:27] = OP_BR;
      else if (sel < 5)  ins[31:27] = OP_CMP;
      else if (ins[31:27] == OP_HALT) ins[31:27] = 5'h07;
      w = $urandom_range(0, 3);
      pc_exp = mpc;
      model_step(ins, e);
      run_instr(ins, w, 1, o);
      checks++; if (o.fetch_addr !== pc_exp) begin failures++; $display("FAIL rnd%0d_fetch got=%h exp=%h", n, o.fetch_addr, pc_exp); end
      checks++; if (o.cycles !== 4 + w) begin failures++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", n, o.cycles, 4 + w); end
      checks++; if (o.next_addr !== e.next) begin failures++; $display("FAIL rnd%0d_next got=%h exp=%h", n, o.next_addr, e.next); end
      checks++; if (o.we_cnt !== int'(e.we) || o.halted_seen) begin failures++; $display("FAIL rnd%0d_we got=%0d exp=%0d", n, o.we_cnt, e.we); end
      if (e.we) begin
        checks++; if (o.z_data !== e.data || o.z_addr !== e.addr || o.zsel !== e.zsel) begin
          failures++; $display("FAIL rnd%0d_write got=%h@%0d/%b exp=%h@%0d/%b", n, o.z_data, o.z_addr, o.zsel, e.data, e.addr, e.zsel); end
      end
    end
  endtask

  task automatic test_reset_wb();
    obs_t o; exp_t e;
    logic [31:0] prev;
    do_reset();
    model_step(mk_i(OP_MOV, 0, 0, 0, 5'd7, 16'h0055), e);
    run_instr(mk_i(OP_MOV, 0, 0, 0, 5'd7, 16'h0055), 0, 0, o);
    prev = regs[7];
    imem_ack = 1'b1; imem_data = mk_i(OP_MOV, 0, 0, 0, 5'd7, 16'h00AA);
    @(negedge clk); #1; imem_ack = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL rwb_in_wb got=%b exp=1", rf_we); end
    rst = 1'b1; #1;
    checks++; if (rf_we !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rwb_abort got=we%b req%b exp=0/0", rf_we, imem_req); end
    checks++; if (pc !== RPC) begin failures++; $display("FAIL rwb_pc got=%h exp=%h", pc, RPC); end
    @(posedge clk); #1;
    checks++; if (regs[7] !== prev || prev !== 32'h55) begin failures++; $display("FAIL rwb_no_write got=%h exp=00000055", regs[7]); end
    @(negedge clk); rst = 1'b0; #1;
    mpc = RPC;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin failures++; $display("FAIL rwb_resume got=req%b addr=%h exp=1/%h", imem_req, imem_addr, RPC); end
  endtask

  initial begin
    imem_ack = 1'b0; imem_data = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 8; i++) mpreds[i] = 1'b0;
    mpc = RPC;
    test_reset();
    test_mov();
    test_wait_states();
    test_branch();
    test_pred_branch();
    test_halt();
    test_random();
    test_reset_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Parametrised multicycle instruction sequencer: next-generation control core replacing the fixed four-state control loop inside the CPU top level. Fetches instructions over a req/ack handshake so instruction memory may take variable wait states. Sequences FETCH/DECODE/EXECUTE/WRITE_BACK and drives an external ALU and register bank. Adds conditional predicated branches and a HALT state.

## Interface
- WIDTH, 32, datapath and PC width (≥16)
- REG_SEL, 5, general register address width
- PRED_SEL, 3, predicate register address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  WIDTH  fetch address (word address)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  instruction word
- rf_addr_a / rf_addr_b  out  REG_SEL  source register selects
- rf_data_a / rf_data_b  in  WIDTH  source register data (combinational read)
- rf_we  out  1  register write strobe
- rf_addr_z  out  REG_SEL  destination select
- rf_z_sel  out  1  1 = write predicate bank (CMP)
- rf_data_z  out  WIDTH  write data
- pred_addr  out  PRED_SEL  predicate read select
- pred_val  in  1  selected predicate bit
- alu_opcode  out  5  inst[31:27]
- alu_cc  out  3  inst[12:10] for CMP, else 0
- alu_a / alu_b  out  WIDTH  ALU operands
- alu_z  in  WIDTH  ALU result (combinational)
- pc  out  WIDTH  current PC
- halted  out  1  core in HALTED state

## Operation
- States: FETCH, DECODE, EXECUTE, WRITE_BACK, HALTED.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_data into inst register → DECODE. No ack → stay.
- DECODE: register sources read; has_imm (MOV, BR) selects alu_a = sign-extended inst[15:0], alu_b = 0; otherwise alu_a/b = rf_data_a/b (addr_a = inst[9:5], addr_b = inst[4:0]). Latch operands → EXECUTE. HALT opcode → HALTED.
- EXECUTE: latch alu_z into result register; for BR sample pred_val (pred_addr = inst[25:23]) → WRITE_BACK.
- WRITE_BACK: rf_we=1 for one cycle unless BR; rf_addr_z = inst[20:16]; rf_z_sel = is CMP; rf_data_z = result. PC update: BR taken → pc + sext(inst[15:0]); otherwise pc + 1. → FETCH.
- Branch taken: inst[26]=0 unconditional; inst[26]=1 taken iff pred_val XOR inst[22] == 1.
- PC arithmetic modulo 2^WIDTH; wrap-around silent.
- HALTED: all strobes 0, pc frozen; exit only via reset.
- Unknown opcodes execute as ALU ops with writeback (no trap).

## Timing
- Reset values: state FETCH, pc = RESET_PC, inst = 0, halted 0, rf_we 0; imem_req = 0 while reset asserted, 1 first cycle after release.
- Instruction latency: 4 cycles + fetch wait cycles (ack in first FETCH cycle → 4).
- imem_ack sampled only while imem_req=1; ack with req low ignored.
- imem_addr stable while imem_req held.
- rf_we asserted exactly one cycle per non-branch, non-halt instruction.
- Reset mid-fetch or mid-writeback: aborts immediately; no write occurs after reset edge; pending ack discarded.
- pc output changes only on the WRITE_BACK → FETCH edge.

## Configuration
- CPU_SEQ_PRED_BRANCH_EN defined: conditional branches as above.
- Undefined: inst[26] and inst[22] ignored, every BR taken; pred_addr driven 0; pred_val unused.

## Structure
- Opcode constants (MOV, BR, CMP, HALT), state encodings, and instruction field positions in shared defines header with existing WIDTH/REG_SEL.
- One sub-module: cpu_seq_decode — combinational decode of latched inst into is_mov/is_branch/is_cmp/is_halt, has_imm, register selects, cc, immediate.

## Test plan
- Reset release, ack same cycle, MOV r3,#0x8001 → rf_we pulse 4 cycles later, rf_data_z = 0xFFFF8001, addr_z 3, pc 0→1.
- Fetch with 3 wait cycles → imem_req held, imem_addr stable, instruction completes in 7 cycles.
- BR +(-2) at pc 5, unconditional → no rf_we, next imem_addr = 3; BR -1 at pc 0 → wrap to 0xFFFFFFFF.
- CMP writes predicate 2, then conditional BR on p2 with inst[22]=0: pred_val 1 → taken; pred_val 0 → pc+1; macro off → taken regardless.
- HALT → halted=1, imem_req stays 0 for 20 cycles; reset → pc = RESET_PC, fetch resumes.
- Assert reset during WRITE_BACK → rf_we falls immediately, no write, pc = RESET_PC.
